vga_pix_fifo: RTL
=================

VGA_PIX_FIFO -- requirements
Module: vga_pix_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, default 512, FIFO entries; PREFILL, default 256, level required before display starts.
REQ-002 clk65M  in  1  pixel clock, 65 MHz, single clock domain.
REQ-003 rstn  in  1  reset: asynchronous, active-low.
REQ-004 wr_valid  in  1  upstream pixel word valid.
REQ-005 wr_ready  out  1  block can accept a word this cycle.
REQ-006 wr_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-007 wr_sof  in  1  qualifies wr_data as the first pixel of a frame.
REQ-008 frame_start  in  1  one-cycle pulse from the timing generator at the start of vertical sync.
REQ-009 pix_req  in  1  timing generator consumes one active pixel this cycle.
REQ-010 pix_data  out  24  registered pixel to the timing generator's RGB outputs.
REQ-011 pix_valid  out  1  pix_data came from the FIFO, not a black substitute.
REQ-012 underflow  out  1  sticky: at least one starved pix_req in the current frame.
REQ-013 underflow_cnt  out  16  starved pix_req count in the current frame, saturating.
REQ-014 level  out  10  current FIFO occupancy, 0..DEPTH.

Function
REQ-015 Storage SHALL be a DEPTH x 24 circular buffer with 9-bit read/write pointers that wrap 511->0; level SHALL be tracked as a separate 10-bit counter.
REQ-016 A write SHALL occur when wr_valid && wr_ready and the state admits writes; wr_ready SHALL be 1 in SYNC, and level<DEPTH in FILL/RUN.
REQ-017 The state machine SHALL use the states SYNC, FILL and RUN.
REQ-018 SYNC: words with wr_sof=0 SHALL be accepted and discarded; the first accepted word with wr_sof=1 SHALL be written and the state SHALL move to FILL.
REQ-019 FILL: words SHALL be written; pix_req SHALL be ignored with no read and no underflow; the state SHALL move to RUN the cycle after level>=PREFILL.
REQ-020 RUN: each pix_req with level>0 SHALL read one word; pix_data SHALL equal that word and pix_valid=1 on the next cycle (latency 1).
REQ-021 RUN with pix_req and level==0: pix_data SHALL be 0, pix_valid=0, underflow set, underflow_cnt incremented (saturating at 0xFFFF); pointers SHALL be unchanged.
REQ-022 Without pix_req, pix_data SHALL be 0 and pix_valid=0 on the next cycle.
REQ-023 Simultaneous read and write SHALL leave level unchanged, including at level==DEPTH-1 and level==1.
REQ-024 Full (level==DEPTH): wr_ready=0, so writes are blocked; a read in the same cycle SHALL still occur, and wr_ready SHALL return to 1 on the next cycle.
REQ-025 frame_start in any state SHALL flush the FIFO (pointers=0, level=0), clear underflow and underflow_cnt, enter SYNC, and block any write or read in that cycle.
REQ-026 A wr_sof word arriving in RUN SHALL be written as an ordinary pixel; realignment SHALL occur only through frame_start.
REQ-027 pix_data SHALL be 0 whenever pix_valid=0, so that blanking carries no residual colour.

Reset
REQ-028 On rstn low, asynchronously: state=SYNC, pointers=0, level=0, pix_data=0, pix_valid=0, underflow=0, underflow_cnt=0; wr_ready SHALL still evaluate to 1 (SYNC).
REQ-029 Reset mid-frame SHALL discard all stored pixels; operation SHALL resume at the next wr_sof.

Structure
REQ-030 The shared VGA package SHALL hold the pixel width (24), the DEPTH/PREFILL defaults and the state encoding constants.
REQ-031 Storage SHALL be one sub-module, vga_pix_ram: simple dual-port, synchronous write, registered read, inferable as block RAM.
REQ-032 Control, pointers and counters SHALL remain in vga_pix_fifo; total RTL is 150-300 lines.

Verification
REQ-033 Reset, then 5 words without sof followed by sof word 0x112233 and 299 more words -> first 5 discarded; RUN entered after level reaches 256; first pix_req returns 0x112233 with pix_valid=1 one cycle later.
REQ-034 Write 512 words with no pix_req -> wr_ready=0 at level 512; one pix_req with wr_valid high -> read occurs, level=511, wr_ready=1 on the next cycle.
REQ-035 In RUN, drain to level 0 then 3 further pix_req -> pix_data=0, pix_valid=0, underflow=1, underflow_cnt=3.
REQ-036 Concurrent read and write every cycle for 2000 cycles at level 256 -> level constant, output order equals input order across pointer wrap.
REQ-037 frame_start mid-RUN at level 300 with pix_req high -> next cycle level=0, state SYNC, underflow=0, pix_valid=0.

Source files
------------

// File: rtl/vga_pix_fifo_pkg.sv
// Shared VGA pixel-path types: pixel width, FIFO sizing defaults, FSM encoding.
// Pure declarations; no latency or backpressure of its own.
package vga_pix_fifo_pkg;

    localparam int PIX_W       = 24;
    localparam int DEPTH_DEF   = 512;
    localparam int PREFILL_DEF = 256;
    localparam int LVL_W       = 10;
    localparam int UCNT_W      = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_pix_ram.sv
// Simple dual-port pixel store: synchronous write, registered read (block RAM shape).
// Read data valid one cycle after rd_en; no backpressure, caller guarantees addresses.
module vga_pix_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int W     = 24
) (
    input  logic          clk65M,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map this onto BRAM.
    always_ff @(posedge clk65M) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_pix_fifo.sv
// Frame-aligned pixel FIFO feeding the VGA timing generator; pix_data one cycle after pix_req.
// Backpressure via wr_ready (low only when full in FILL/RUN); starved requests yield black.
module vga_pix_fifo
    import vga_pix_fifo_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PREFILL = PREFILL_DEF
) (
    input  logic              clk65M,
    input  logic              rstn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              wr_sof,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic [UCNT_W-1:0] underflow_cnt,
    output logic [LVL_W-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] PRE_LVL  = LVL_W'(PREFILL);

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           accept;
    logic           wr_en;
    logic           rd_en;
    logic           starve;
    pix_t           ram_q;

    always_comb begin
        state_nxt = state;
        wr_ready  = (state == ST_SYNC) || (level != FULL_LVL);
        accept    = wr_valid && wr_ready;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        starve    = 1'b0;
        if (frame_start) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                // Pre-sof words are accepted and dropped so upstream can run freely.
                ST_SYNC: begin
                    if (accept && wr_sof) begin
                        wr_en     = 1'b1;
                        state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    wr_en = accept;
                    if (level >= PRE_LVL) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    wr_en  = accept;
                    rd_en  = pix_req && (level != '0);
                    starve = pix_req && (level == '0);
                end
                default: state_nxt = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk65M or negedge rstn) begin
        if (!rstn) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk65M or negedge rstn) begin
        if (!rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            pix_valid     <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            pix_valid <= rd_en;
            if (frame_start) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level         <= '0;
                underflow     <= 1'b0;
                underflow_cnt <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level <= level + LVL_W'(wr_en) - LVL_W'(rd_en);
                if (starve) begin
                    underflow     <= 1'b1;
                    underflow_cnt <= sat_inc(underflow_cnt);
                end
            end
        end
    end

    vga_pix_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (PIX_W)
    ) u_ram (
        .clk65M  (clk65M),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // RAM output is unreset; masking keeps blanking black and hides stale reads.
    assign pix_data = pix_valid ? ram_q : '0;

endmodule
